// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle processor control FSM (optional illegal-opcode trap: ILLEGAL_OP_TRAP_EN)
package main_fsm_pkg;
   typedef enum logic [2:0] {
      alu_ADD     = 3'd0,
      alu_SUB     = 3'd1,
      alu_AND     = 3'd2,
      alu_OR      = 3'd3,
      alu_XOR     = 3'd4,
      alu_SLT     = 3'd5,
      alu_LU      = 3'd6,
      alu_regtype = 3'd7
   } alu_t;
endpackage

module main_fsm
   import main_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       branch,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] pcsrc,
   output alu_t       aluop,
   output logic [3:0] state_o,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      RTEX   = 4'd6,
      ALUWB  = 4'd7,
      BEQEX  = 4'd8,
      IEX    = 4'd9,
      IWB    = 4'd10,
      JEX    = 4'd11,
      TRAP   = 4'd12
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_op_legal;
   // Strobes are gated by reset_n so FETCH cannot load PC/IR while reset is held
   logic   w_mem_ready_g;

   assign w_mem_ready_g = mem_ready & reset_n;
   assign state_o       = r_state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= FETCH;
      else          r_state <= w_next;
   end

   always_comb begin
      w_op_legal = 1'b1;
      case (op)
         6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
         6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111: w_op_legal = 1'b1;
         default: w_op_legal = 1'b0;
      endcase
   end

`ifdef ILLEGAL_OP_TRAP_EN
   logic r_illegal_op;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           r_illegal_op <= 1'b0;
      else if (r_state == DECODE && !w_op_legal) r_illegal_op <= 1'b1;
   end
   assign illegal_op = r_illegal_op;
`else
   assign illegal_op = 1'b0;
`endif

   always_comb begin
      w_next   = r_state;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      pcsrc    = 2'b00;
      aluop    = alu_ADD;
      case (r_state)
         FETCH: begin
            alusrcb = 2'b01;
            irwrite = w_mem_ready_g;
            pcwrite = w_mem_ready_g;
            w_next  = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               6'b100011, 6'b101011: w_next = MEMADR;
               6'b000000:            w_next = RTEX;
               6'b000100:            w_next = BEQEX;
               6'b000010:            w_next = JEX;
               6'b001000, 6'b001010, 6'b001100,
               6'b001101, 6'b001110, 6'b001111: w_next = IEX;
`ifdef ILLEGAL_OP_TRAP_EN
               default:              w_next = TRAP;
`else
               default:              w_next = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            w_next  = (op == 6'b100011) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord   = 1'b1;
            w_next = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            w_next   = FETCH;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            w_next   = mem_ready ? FETCH : MEMWR;
         end
         RTEX: begin
            alusrca = 1'b1;
            aluop   = alu_regtype;
            w_next  = ALUWB;
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            w_next   = FETCH;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = alu_SUB;
            pcsrc   = 2'b01;
            branch  = 1'b1;
            w_next  = FETCH;
         end
         IEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            case (op)
               6'b001010: aluop = alu_SLT;
               6'b001100: aluop = alu_AND;
               6'b001101: aluop = alu_OR;
               6'b001110: aluop = alu_XOR;
               6'b001111: aluop = alu_LU;
               default:   aluop = alu_ADD;
            endcase
            w_next = IWB;
         end
         IWB: begin
            regwrite = 1'b1;
            w_next   = FETCH;
         end
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
            w_next  = FETCH;
         end
         TRAP:    w_next = TRAP;
         default: w_next = FETCH;
      endcase
   end

   logic w_unused;
   assign w_unused = w_op_legal;

endmodule
